laser_timer_param: RTL and testbench

Parametrised successor of the single-pulse laser timer. A button press produces a laser-enable pulse of programmable length. Optional features: retrigger-extend, a post-pulse cooldown lockout, and a synchronous abort. It sits between the debounced trigger input and the laser driver enable, and is configured by the local control logic through a load strobe.

---
 rtl/laser_timer_pkg.sv | 13 +
 rtl/laser_timer_if.sv | 29 ++
 rtl/laser_timer_param.sv | 104 ++++++++++
 tb/tb_laser_timer_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_timer_pkg.sv
// Shared constants for the parametrised laser pulse timer.
// State encoding and power-on configuration defaults.
package laser_timer_pkg;

    localparam int unsigned LT_CNT_W    = 8;
    localparam int unsigned LT_DEF_DUR  = 3;
    localparam int unsigned LT_DEF_COOL = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

endpackage

// File: rtl/laser_timer_if.sv
// Trigger, config and laser-enable bundle for the laser timer.
// Master drives trigger/config; slave (the timer) drives status.
interface laser_timer_if
    import laser_timer_pkg::*;
#(
    parameter int unsigned CNT_W = LT_CNT_W
);

    logic             B;
    logic             Abort;
    logic             Retrig;
    logic             Load;
    logic [CNT_W-1:0] Dur;
    logic [CNT_W-1:0] Cool;
    logic             X;
    logic             Busy;
    logic [CNT_W-1:0] Remaining;

    modport master (
        output B, Abort, Retrig, Load, Dur, Cool,
        input  X, Busy, Remaining
    );

    modport slave (
        input  B, Abort, Retrig, Load, Dur, Cool,
        output X, Busy, Remaining
    );

endinterface

// File: rtl/laser_timer_param.sv
// Laser enable pulse timer with retrigger, cooldown lockout and abort.
// One counter serves both the pulse and the cooldown phase.
module laser_timer_param
    import laser_timer_pkg::*;
#(
    parameter int unsigned CNT_W    = LT_CNT_W,
    parameter int unsigned DEF_DUR  = LT_DEF_DUR,
    parameter int unsigned DEF_COOL = LT_DEF_COOL
) (
    input  logic          Clk,
    input  logic          Rst,
    laser_timer_if.slave  bus
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [CNT_W-1:0] deff_m1;
    logic [CNT_W-1:0] end_cnt;
    logic [1:0]       end_state;

    // Dur of 0 behaves as 1, so the reload value never underflows.
    assign deff_m1   = (dur_q == '0) ? '0 : dur_q - ONE;
    assign end_state = (cool_q != '0) ? S_COOL : S_IDLE;
    assign end_cnt   = (cool_q != '0) ? cool_q - ONE : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        cool_d  = cool_q;
        x_d     = x_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Load) begin
                    dur_d  = bus.Dur;
                    cool_d = bus.Cool;
                end
                if (bus.B && !bus.Abort) begin
                    state_d = S_ON;
                    x_d     = 1'b1;
                    cnt_d   = deff_m1;
                end
            end
            S_ON: begin
                if (bus.Abort || (!(bus.Retrig && bus.B) && cnt_q == '0)) begin
                    x_d     = 1'b0;
                    state_d = end_state;
                    cnt_d   = end_cnt;
                end else if (bus.Retrig && bus.B) begin
                    cnt_d = deff_m1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_COOL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                x_d     = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        rem_d  = (state_d == S_ON) ? cnt_d : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dur_q   <= CNT_W'(DEF_DUR);
            cool_q  <= CNT_W'(DEF_COOL);
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            cool_q  <= cool_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.X         = x_q;
    assign bus.Busy      = busy_q;
    assign bus.Remaining = rem_q;

endmodule

// File: tb/tb_laser_timer_param.sv
// Directed plus randomized bench for laser_timer_param against a cycle model.
module tb_laser_timer_param;

    localparam int CW = 8;

    logic Clk;
    logic Rst;

    laser_timer_if #(.CNT_W(CW)) bus();

    laser_timer_param #(.CNT_W(CW), .DEF_DUR(3), .DEF_COOL(0)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: phase 0 idle, 1 pulsing, 2 locked out.
    // pulse_left counts X-high cycles still to come, including this one.
    int m_phase, m_pulse_left, m_lock_left, m_dur, m_cool;
    int xcnt, bcnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_finish();
        if (m_cool > 0) begin
            m_phase     = 2;
            m_lock_left = m_cool;
        end else begin
            m_phase = 0;
        end
        m_pulse_left = 0;
    endtask

    task automatic model_edge();
        int deff;
        deff = (m_dur < 1) ? 1 : m_dur;
        if (!Rst) begin
            m_phase = 0; m_pulse_left = 0; m_lock_left = 0;
            m_dur = 3; m_cool = 0;
        end else if (m_phase == 0) begin
            if (bus.B && !bus.Abort) begin
                m_phase = 1;
                m_pulse_left = deff;
            end
            if (bus.Load) begin
                m_dur  = int'(bus.Dur);
                m_cool = int'(bus.Cool);
            end
        end else if (m_phase == 1) begin
            if (bus.Abort) model_finish();
            else if (bus.Retrig && bus.B) m_pulse_left = deff;
            else if (m_pulse_left == 1) model_finish();
            else m_pulse_left--;
        end else begin
            if (m_lock_left == 1) m_phase = 0;
            else m_lock_left--;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check("X", int'(bus.X), (m_phase == 1) ? 1 : 0);
        check("Busy", int'(bus.Busy), (m_phase != 0) ? 1 : 0);
        check("Remaining", int'(bus.Remaining),
              (m_phase == 1) ? m_pulse_left - 1 : 0);
        if (bus.X) xcnt++;
        if (bus.Busy) bcnt++;
    endtask

    task automatic idle_inputs();
        bus.B = 0; bus.Abort = 0; bus.Retrig = 0; bus.Load = 0;
        bus.Dur = '0; bus.Cool = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_cfg(input int d, input int c);
        bus.Load = 1; bus.Dur = CW'(d); bus.Cool = CW'(c);
        step();
        bus.Load = 0;
    endtask

    task automatic press();
        bus.B = 1;
        step();
        bus.B = 0;
    endtask

    task automatic wait_rem(input int val);
        int k;
        k = 0;
        while (!(bus.X && int'(bus.Remaining) == val) && k < 40) begin
            step();
            k++;
        end
        check("wait_remaining_timeout", (k < 40) ? 1 : 0, 1);
    endtask

    initial begin
        idle_inputs();
        Rst = 0;
        m_phase = 0; m_pulse_left = 0; m_lock_left = 0;
        m_dur = 3; m_cool = 0;
        run(2);
        check("reset_X", int'(bus.X), 0);
        check("reset_Busy", int'(bus.Busy), 0);
        check("reset_Rem", int'(bus.Remaining), 0);
        Rst = 1;

        // Default 3-cycle pulse
        xcnt = 0; bcnt = 0;
        press();
        check("def_first_rem", int'(bus.Remaining), 2);
        run(6);
        check("def_len", xcnt, 3);
        check("def_busy", bcnt, 3);

        // Dur 5 / Cool 4, B during cooldown ignored
        load_cfg(5, 4);
        xcnt = 0; bcnt = 0;
        press();
        run(6);
        press();
        run(8);
        check("cool_len_x", xcnt, 5);
        check("cool_len_busy", bcnt, 9);
        xcnt = 0;
        press();
        run(10);
        check("after_cool_len", xcnt, 5);

        // Retrigger extends; without retrigger it does not
        load_cfg(4, 0);
        xcnt = 0;
        bus.Retrig = 1;
        press();
        wait_rem(1);
        press();
        run(10);
        check("retrig_len", xcnt, 7);
        xcnt = 0;
        bus.Retrig = 0;
        press();
        wait_rem(1);
        press();
        run(10);
        check("noretrig_len", xcnt, 4);

        // Abort mid-pulse, and Abort with B in idle
        load_cfg(6, 0);
        press();
        wait_rem(2);
        bus.Abort = 1;
        step();
        check("abort_X", int'(bus.X), 0);
        check("abort_Busy", int'(bus.Busy), 0);
        check("abort_Rem", int'(bus.Remaining), 0);
        xcnt = 0;
        bus.B = 1;
        step();
        bus.B = 0; bus.Abort = 0;
        run(3);
        check("abort_idle_nopulse", xcnt, 0);

        // Dur 0 acts as 1; Load while ON is ignored
        load_cfg(0, 0);
        xcnt = 0;
        press();
        run(4);
        check("dur0_len", xcnt, 1);
        load_cfg(5, 0);
        xcnt = 0;
        press();
        load_cfg(7, 0);
        run(8);
        xcnt = 0;
        press();
        run(10);
        check("load_on_ignored", xcnt, 5);

        // Reset mid-pulse and mid-cooldown restores defaults
        load_cfg(6, 3);
        press();
        wait_rem(3);
        Rst = 0;
        step();
        check("rst_pulse_X", int'(bus.X), 0);
        check("rst_pulse_Busy", int'(bus.Busy), 0);
        Rst = 1;
        xcnt = 0;
        press();
        run(6);
        check("rst_pulse_default", xcnt, 3);
        load_cfg(2, 5);
        press();
        run(3);
        check("in_cool_busy", int'(bus.Busy), 1);
        Rst = 0;
        step();
        check("rst_cool_Busy", int'(bus.Busy), 0);
        Rst = 1;
        xcnt = 0; bcnt = 0;
        press();
        run(6);
        check("rst_cool_default_x", xcnt, 3);
        check("rst_cool_default_busy", bcnt, 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.B      = ($urandom_range(0, 3) == 0);
            bus.Abort  = ($urandom_range(0, 15) == 0);
            bus.Retrig = ($urandom_range(0, 1) == 1);
            bus.Load   = ($urandom_range(0, 7) == 0);
            bus.Dur    = CW'($urandom_range(0, 6));
            bus.Cool   = CW'($urandom_range(0, 4));
            Rst        = ($urandom_range(0, 99) != 0);
            step();
        end
        Rst = 1;
        idle_inputs();
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
